// File: rtl/spi_module.sv
// SPI mode-0 slave, fully in the clk domain with oversampled sck/mosi/ncs.
// An 8-bit command selects a 32-bit register access or a 16-bit memory read stream.
module spi_module #(
  parameter int SYNC_STAGES = 2,
  parameter int MEM_AW      = 12,
  parameter int MEM_DW      = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              sck,
  input  logic              mosi,
  input  logic              ncs,
  output logic              miso,
  input  logic [31:0]       data_in_1,
  output logic [7:0]        q_c,
  output logic [31:0]       q_0,
  output logic [31:0]       q_1,
  input  logic [MEM_DW-1:0] mem_data,
  output logic [MEM_AW-1:0] mem_addr
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_MEM,
    ST_DONE
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] ncs_sync_q, ncs_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   ncs_prev_q, ncs_prev_d;
  logic [4:0]             bit_cnt_q, bit_cnt_d;
  logic [31:0]            rx_q, rx_d;
  logic [31:0]            tx_q, tx_d;
  logic [31:0]            snap_q, snap_d;
  logic                   wr_pend_q, wr_pend_d;
  logic                   miso_q, miso_d;
  logic [7:0]             q_c_q, q_c_d;
  logic [31:0]            q_0_q, q_0_d;
  logic [31:0]            q_1_q, q_1_d;
  logic [MEM_AW-1:0]      mem_addr_q, mem_addr_d;

  logic sck_s, mosi_s, ncs_s;
  logic sck_rise, sck_fall;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign ncs_s    = ncs_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;

  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], ncs};
    sck_prev_d  = sck_s;
    ncs_prev_d  = ncs_s;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    snap_d      = snap_q;
    wr_pend_d   = 1'b0;
    q_c_d       = q_c_q;
    q_0_d       = q_0_q;
    q_1_d       = q_1_q;
    mem_addr_d  = mem_addr_q;

    // A completed write lands one clk after the 32nd bit, even if ncs has since risen.
    if (wr_pend_q) begin
      if (q_c_q[4]) q_1_d = rx_q;
      else          q_0_d = rx_q;
    end

    if (ncs_s) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 5'd0;
      tx_d      = 32'd0;
    end else if (ncs_prev_q) begin
      state_d   = ST_CMD;
      bit_cnt_d = 5'd0;
      tx_d      = {q_c_q, 24'd0};
    end else if (sck_rise) begin
      rx_d = {rx_q[30:0], mosi_s};
      case (state_q)
        ST_CMD: begin
          if (bit_cnt_q == 5'd7) begin
            q_c_d     = rx_d[7:0];
            bit_cnt_d = 5'd0;
            if (rx_d[1]) begin
              state_d    = ST_MEM;
              mem_addr_d = '0;
            end else begin
              state_d = ST_DATA;
              snap_d  = rx_d[4] ? data_in_1 : q_0_q;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        ST_DATA: begin
          if (bit_cnt_q == 5'd31) begin
            state_d   = ST_DONE;
            bit_cnt_d = 5'd0;
            wr_pend_d = q_c_q[0];
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        ST_MEM: begin
          if (bit_cnt_q == 5'(MEM_DW - 1)) begin
            bit_cnt_d  = 5'd0;
            mem_addr_d = mem_addr_q + {{(MEM_AW-1){1'b0}}, 1'b1};
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        default: ;
      endcase
    end else if (sck_fall) begin
      // A falling edge with the counter at zero begins a new word: load instead of shift.
      case (state_q)
        ST_CMD:  tx_d = {tx_q[30:0], 1'b0};
        ST_DATA: tx_d = (bit_cnt_q == 5'd0) ? snap_q : {tx_q[30:0], 1'b0};
        ST_MEM:  tx_d = (bit_cnt_q == 5'd0) ? {mem_data, {(32-MEM_DW){1'b0}}}
                                            : {tx_q[30:0], 1'b0};
        default: tx_d = 32'd0;
      endcase
    end

    miso_d = ((state_d == ST_CMD) || (state_d == ST_DATA) || (state_d == ST_MEM))
             ? tx_d[31] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      ncs_sync_q  <= '1;
      sck_prev_q  <= 1'b0;
      ncs_prev_q  <= 1'b1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 5'd0;
      rx_q        <= 32'd0;
      tx_q        <= 32'd0;
      snap_q      <= 32'd0;
      wr_pend_q   <= 1'b0;
      miso_q      <= 1'b0;
      q_c_q       <= 8'd0;
      q_0_q       <= 32'd0;
      q_1_q       <= 32'd0;
      mem_addr_q  <= '0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ncs_sync_q  <= ncs_sync_d;
      sck_prev_q  <= sck_prev_d;
      ncs_prev_q  <= ncs_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      snap_q      <= snap_d;
      wr_pend_q   <= wr_pend_d;
      miso_q      <= miso_d;
      q_c_q       <= q_c_d;
      q_0_q       <= q_0_d;
      q_1_q       <= q_1_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  assign miso     = miso_q;
  assign q_c      = q_c_q;
  assign q_0      = q_0_q;
  assign q_1      = q_1_q;
  assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_spi_module.sv
// Bench for spi_module: directed and random SPI transactions checked against
// a transaction-level model of the register file and memory stream.
module tb_spi_module;
  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        sck = 1'b0;
  logic        mosi = 1'b0;
  logic        ncs = 1'b1;
  logic        miso;
  logic [31:0] data_in_1;
  logic [7:0]  q_c;
  logic [31:0] q_0;
  logic [31:0] q_1;
  logic [15:0] mem_data;
  logic [11:0] mem_addr;

  logic [15:0] din_hi = 16'hBABE;
  logic [3:0]  mem_hi = 4'hE;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  m_qc = 8'd0;
  logic [31:0] m_q0 = 32'd0;
  logic [31:0] m_q1 = 32'd0;
  logic [31:0] exp_q[$];

  assign data_in_1 = {din_hi, q_0[15:0]};
  assign mem_data  = {mem_hi, mem_addr};

  spi_module dut (
    .clk      (clk),
    .nreset   (nreset),
    .sck      (sck),
    .mosi     (mosi),
    .ncs      (ncs),
    .miso     (miso),
    .data_in_1(data_in_1),
    .q_c      (q_c),
    .q_0      (q_0),
    .q_1      (q_1),
    .mem_data (mem_data),
    .mem_addr (mem_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Host side of one mode-0 bit: present mosi, sample miso at the rising edge.
  task automatic shift_bit(input logic b, output logic o);
    mosi = b;
    repeat (HALF) @(negedge clk);
    o = miso;
    sck = 1'b1;
    repeat (HALF) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic cs_low();
    ncs = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge clk);
    ncs = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic do_reg(input logic [7:0] cmd, input logic [31:0] data, input int ndata);
    logic [7:0]  st, exp_st;
    logic [31:0] rd, exp_rd, full;
    logic        b;
    exp_st = m_qc;
    m_qc   = cmd;
    full   = cmd[4] ? {din_hi, m_q0[15:0]} : m_q0;
    exp_rd = (ndata == 0) ? 32'd0 : (full >> (32 - ndata));
    if (ndata == 32 && cmd[0]) begin
      if (cmd[4]) m_q1 = data;
      else        m_q0 = data;
    end
    cs_low();
    st = 8'd0;
    for (int i = 0; i < 8; i++) begin
      shift_bit(cmd[7-i], b);
      st = {st[6:0], b};
    end
    rd = 32'd0;
    for (int i = 0; i < ndata; i++) begin
      shift_bit(data[31-i], b);
      rd = {rd[30:0], b};
    end
    cs_high();
    check("status", {24'd0, st}, {24'd0, exp_st});
    check("rdata", rd, exp_rd);
    check("q_c", {24'd0, q_c}, {24'd0, m_qc});
    check("q_0", q_0, m_q0);
    check("q_1", q_1, m_q1);
    check("miso_idle", {31'd0, miso}, 32'd0);
  endtask

  task automatic do_mem(input logic [7:0] cmd, input int nwords);
    logic [7:0]  st, exp_st;
    logic [15:0] w;
    logic        b;
    exp_st = m_qc;
    m_qc   = cmd;
    for (int k = 0; k < nwords; k++) exp_q.push_back({16'd0, mem_hi, 12'(k)});
    cs_low();
    st = 8'd0;
    for (int i = 0; i < 8; i++) begin
      shift_bit(cmd[7-i], b);
      st = {st[6:0], b};
    end
    for (int k = 0; k < nwords; k++) begin
      w = 16'd0;
      for (int i = 0; i < 16; i++) begin
        shift_bit(1'($urandom_range(0, 1)), b);
        w = {w[14:0], b};
      end
      check("mem_word", {16'd0, w}, exp_q.pop_front());
    end
    check("mem_addr_end", {20'd0, mem_addr}, {20'd0, 12'(nwords)});
    cs_high();
    check("mem_status", {24'd0, st}, {24'd0, exp_st});
    check("mem_q_c", {24'd0, q_c}, {24'd0, m_qc});
  endtask

  initial begin
    logic b;
    int   nd;

    repeat (3) @(negedge clk);
    check("rst_q_c", {24'd0, q_c}, 32'd0);
    check("rst_q_0", q_0, 32'd0);
    check("rst_q_1", q_1, 32'd0);
    check("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
    check("rst_miso", {31'd0, miso}, 32'd0);
    nreset = 1'b1;
    repeat (4) @(negedge clk);

    do_reg(8'hA4, 32'h24AF55AA, 32);
    do_reg(8'h55, 32'h01234567, 32);
    do_reg(8'hA5, 32'h0000CAFE, 32);
    do_reg(8'hA4, $urandom, 32);
    do_reg(8'h51, 32'h01010202, 32);
    do_mem(8'h02, 16);

    do_reg(8'h51, $urandom, 20);

    for (int t = 0; t < 10; t++) begin
      din_hi = 16'($urandom);
      nd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 31)) : 32;
      do_reg(8'($urandom) & 8'hFD, $urandom, nd);
    end

    for (int t = 0; t < 2; t++) begin
      mem_hi = 4'($urandom);
      do_mem(8'($urandom) | 8'h02, int'($urandom_range(3, 6)));
    end

    cs_low();
    for (int i = 0; i < 12; i++) shift_bit(1'($urandom_range(0, 1)), b);
    nreset = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_q_c", {24'd0, q_c}, 32'd0);
    check("mid_rst_q_0", q_0, 32'd0);
    check("mid_rst_q_1", q_1, 32'd0);
    check("mid_rst_mem_addr", {20'd0, mem_addr}, 32'd0);
    check("mid_rst_miso", {31'd0, miso}, 32'd0);
    ncs = 1'b1;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    m_qc = 8'd0;
    m_q0 = 32'd0;
    m_q1 = 32'd0;
    repeat (2 * HALF) @(negedge clk);
    din_hi = 16'hBABE;
    do_reg(8'hA5, $urandom, 32);
    do_reg(8'hA4, 32'h0, 32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
